// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage for the RISC-V core.
// Owns the PC and issues word-aligned requests on a valid/ready channel.
// In-order responses are tagged with their PC and buffered in a small FIFO.
// Taken branches redirect the PC and flush everything in flight.
// Optional build macro FETCH_PERF_EN adds perf_fetched / perf_flushes counters.
module fetch_unit #(
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter int                FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_resp_valid,
  input  logic [31:0]       imem_resp_data,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic [6:0]        op,
  output logic [2:0]        funct3,
  output logic              funct7
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_flushes
`endif
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  // Stale responses can pile up across repeated redirects, so the drop
  // counter is much wider than the in-flight limit.
  localparam int DROP_W = 16;
  localparam logic [CNT_W:0] CREDIT_MAX = (CNT_W + 1)'(FIFO_DEPTH);

  logic [ADDR_W-1:0] fetch_pc;
  logic [CNT_W-1:0]  outstanding;
  logic [DROP_W-1:0] drop;

  logic [ADDR_W-1:0] tag_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  tag_wr;
  logic [PTR_W-1:0]  tag_rd;

  logic [31:0]       fifo_instr [FIFO_DEPTH];
  logic [ADDR_W-1:0] fifo_pc    [FIFO_DEPTH];
  logic [PTR_W-1:0]  fifo_wr;
  logic [PTR_W-1:0]  fifo_rd;
  logic [CNT_W-1:0]  fifo_count;

  logic [CNT_W:0]    in_use;
  logic              fire;
  logic              resp_drop;
  logic              resp_take;
  logic              pop;
  logic              unused_tgt_lsb;

  // Credits cover both buffered and in-flight words, so responses never
  // need back-pressure.
  assign in_use         = {1'b0, fifo_count} + {1'b0, outstanding};
  assign imem_req_valid = !reset && (in_use < CREDIT_MAX);
  assign imem_req_addr  = fetch_pc;
  assign fire           = imem_req_valid && imem_req_ready;

  assign resp_drop = imem_resp_valid && (drop != '0);
  assign resp_take = imem_resp_valid && (drop == '0) && (outstanding != '0);

  assign instr_valid = !reset && (fifo_count != '0);
  assign pop         = instr_valid && instr_ready;
  assign instr       = instr_valid ? fifo_instr[fifo_rd] : '0;
  assign instr_pc    = instr_valid ? fifo_pc[fifo_rd] : '0;
  assign op          = instr[6:0];
  assign funct3      = instr[14:12];
  assign funct7      = instr[30];

  assign unused_tgt_lsb = ^redirect_target[1:0];

  // PC, credit, drop and FIFO pointer bookkeeping; redirect flushes all.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
      tag_wr      <= '0;
      tag_rd      <= '0;
      fifo_wr     <= '0;
      fifo_rd     <= '0;
      fifo_count  <= '0;
    end else if (redirect) begin
      fetch_pc    <= {redirect_target[ADDR_W-1:2], 2'b00};
      outstanding <= '0;
      drop        <= drop + DROP_W'(outstanding) + DROP_W'(fire)
                     - DROP_W'(resp_drop || resp_take);
      tag_wr      <= '0;
      tag_rd      <= '0;
      fifo_wr     <= '0;
      fifo_rd     <= '0;
      fifo_count  <= '0;
    end else begin
      if (fire) begin
        fetch_pc <= fetch_pc + ADDR_W'(4);
        tag_wr   <= tag_wr + 1'b1;
      end
      if (resp_drop) begin
        drop <= drop - 1'b1;
      end
      if (resp_take) begin
        tag_rd  <= tag_rd + 1'b1;
        fifo_wr <= fifo_wr + 1'b1;
      end
      if (pop) begin
        fifo_rd <= fifo_rd + 1'b1;
      end
      outstanding <= outstanding + CNT_W'(fire) - CNT_W'(resp_take);
      fifo_count  <= fifo_count + CNT_W'(resp_take) - CNT_W'(pop);
    end
  end

  // Tag queue and instruction buffer storage; validity lives in the counters.
  always_ff @(posedge clk) begin
    if (fire) begin
      tag_q[tag_wr] <= fetch_pc;
    end
    if (resp_take) begin
      fifo_instr[fifo_wr] <= imem_resp_data;
      fifo_pc[fifo_wr]    <= tag_q[tag_rd];
    end
  end

`ifdef FETCH_PERF_EN
  // Free-running event counters for fetched words and flush cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched <= '0;
      perf_flushes <= '0;
    end else begin
      if (resp_take) begin
        perf_fetched <= perf_fetched + 32'd1;
      end
      if (redirect) begin
        perf_flushes <= perf_flushes + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: bench for fetch_unit with an in-order memory model and a
// scoreboard of instructions expected at the decode interface.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct7;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_flushes;
`endif

  fetch_unit #(.ADDR_W(32), .RESET_PC(RST_PC), .FIFO_DEPTH(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .redirect       (redirect),
    .redirect_target(redirect_target),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .op             (op),
    .funct3         (funct3),
    .funct7         (funct7)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_flushes   (perf_flushes)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
    int          id;
  } pend_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  pend_t pend_q[$];
  exp_t  exp_q[$];

  int total = 0;
  int bad   = 0;

  int          cyc = 0;
  int          lat = 1;
  int          fire_seq = 0;
  int          stale_before = 0;
  int          fire_count = 0;
  int          pop_count = 0;
  logic [31:0] last_fire_addr = '0;
  logic [31:0] last_pop_pc = '0;
  logic [31:0] exp_pc = RST_PC;
  bit          stray = 1'b0;
  bit          cur_real = 1'b0;
  bit          cur_stale = 1'b0;
  logic [31:0] cur_addr = '0;
  exp_t        head_e;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ {a[29:0], 2'b11};
  endfunction

  // Memory model: returns accepted requests in order after the latency
  // that was in force when each was accepted.
  always @(posedge clk) begin
    #2;
    cyc++;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    cur_real        = 1'b0;
    cur_stale       = 1'b0;
    if (stray) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = 32'h0000_0033;
    end else if (!reset && pend_q.size() != 0 && pend_q[0].due <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_word(pend_q[0].addr);
      cur_real        = 1'b1;
      cur_stale       = (pend_q[0].id < stale_before);
      cur_addr        = pend_q[0].addr;
      void'(pend_q.pop_front());
    end
  end

  // Monitor and scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    if (reset) begin
      pend_q.delete();
      exp_q.delete();
      exp_pc = RST_PC;
    end else begin
      if (!instr_valid) begin
        check_eq("empty_instr", instr, 32'h0);
        check_eq("empty_op", 32'(op), 32'h0);
        check_eq("empty_f3f7", {28'h0, funct3, funct7}, 32'h0);
      end
      if (instr_valid && instr_ready) begin
        check_eq("pop_has_expect", 32'(exp_q.size() != 0), 32'h1);
        if (exp_q.size() != 0) begin
          head_e = exp_q.pop_front();
          check_eq("instr", instr, head_e.instr);
          check_eq("instr_pc", instr_pc, head_e.pc);
          check_eq("op", 32'(op), 32'(head_e.instr[6:0]));
          check_eq("funct3", 32'(funct3), 32'(head_e.instr[14:12]));
          check_eq("funct7", 32'(funct7), 32'(head_e.instr[30]));
        end
        pop_count++;
        last_pop_pc = instr_pc;
      end
      if (imem_resp_valid && cur_real && !cur_stale && !redirect) begin
        exp_q.push_back('{instr: mem_word(cur_addr), pc: cur_addr});
      end
      if (imem_req_valid && imem_req_ready) begin
        check_eq("req_addr", imem_req_addr, exp_pc);
        pend_q.push_back('{addr: imem_req_addr, due: cyc + lat, id: fire_seq});
        fire_seq++;
        fire_count++;
        last_fire_addr = imem_req_addr;
        exp_pc = exp_pc + 32'd4;
      end
      if (redirect) begin
        stale_before = fire_seq;
        exp_q.delete();
        exp_pc = {redirect_target[31:2], 2'b00};
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    redirect = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic wait_pop(input string tag, input int budget);
    int  p0;
    bit  ok;
    p0 = pop_count;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (pop_count != p0) begin
        ok = 1'b1;
        break;
      end
    end
    check_eq({tag, "_wait"}, 32'(ok), 32'h1);
  endtask

  task automatic wait_fires(input string tag, input int n, input int budget);
    int  f0;
    bit  ok;
    f0 = fire_count;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (fire_count - f0 >= n) begin
        ok = 1'b1;
        break;
      end
    end
    check_eq({tag, "_wait"}, 32'(ok), 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0;
    reset = 1'b1;
    imem_req_ready = 1'b0;
    instr_ready = 1'b0;
    redirect = 1'b0;
    redirect_target = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_req_valid", 32'(imem_req_valid), 32'h0);
    check_eq("rst_instr_valid", 32'(instr_valid), 32'h0);
    check_eq("rst_instr_pc", instr_pc, 32'h0);

    // Streaming from reset with 1-cycle memory
    @(posedge clk); #1;
    reset = 1'b0;
    imem_req_ready = 1'b1;
    instr_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_eq("t1_valid", 32'(imem_req_valid), 32'h1);
      check_eq("t1_addr", imem_req_addr, RST_PC + 32'(4 * i));
    end
    @(posedge clk); #1;
    wait_fires("t1_third", 1, 10);
    check_eq("t1_third_addr", last_fire_addr, 32'h8);
    repeat (10) @(posedge clk);

    // Decode stalled: credit limit stops requests at FIFO_DEPTH
    do_reset();
    reset = 1'b0;
    instr_ready = 1'b0;
    f0 = fire_count;
    repeat (8) @(posedge clk);
    #1;
    check_eq("t2_fires", 32'(fire_count - f0), 32'h2);
    @(negedge clk);
    check_eq("t2_req_blocked", 32'(imem_req_valid), 32'h0);
    @(posedge clk); #1;
    instr_ready = 1'b1;
    wait_fires("t2_resume", 1, 10);
    check_eq("t2_resume_addr", last_fire_addr, 32'h8);
    instr_ready = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check_eq("t2_full", 32'(instr_valid), 32'h1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check_eq("rstcyc_instr_valid", 32'(instr_valid), 32'h0);
    check_eq("rstcyc_instr", instr, 32'h0);
    check_eq("rstcyc_instr_pc", instr_pc, 32'h0);
    check_eq("rstcyc_op", 32'(op), 32'h0);
    check_eq("rstcyc_req_valid", 32'(imem_req_valid), 32'h0);

    // Memory stall holds the request stable
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    imem_req_ready = 1'b1;
    instr_ready = 1'b1;
    @(posedge clk); #1;
    imem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("t3_valid_held", 32'(imem_req_valid), 32'h1);
      check_eq("t3_addr_stable", imem_req_addr, 32'h4);
    end
    @(posedge clk); #1;
    imem_req_ready = 1'b1;
    repeat (8) @(posedge clk);

    // Redirect with two requests in flight, 3-cycle latency
    lat = 3;
    do_reset();
    reset = 1'b0;
    wait_fires("t4_two_out", 2, 10);
    redirect = 1'b1;
    redirect_target = 32'h0000_0103;
    @(posedge clk); #1;
    redirect = 1'b0;
    wait_pop("t4_first", 30);
    check_eq("t4_first_pc", last_pop_pc, 32'h100);
    repeat (6) @(posedge clk);

    // Back-to-back redirects: the second target wins
    lat = 2;
    @(posedge clk); #1;
    redirect = 1'b1;
    redirect_target = 32'h0000_0200;
    @(posedge clk); #1;
    redirect_target = 32'h0000_0300;
    @(posedge clk); #1;
    redirect = 1'b0;
    wait_pop("t5_first", 30);
    check_eq("t5_first_pc", last_pop_pc, 32'h300);
    repeat (6) @(posedge clk);

    // Reset with one request outstanding, then a stray response
    lat = 3;
    @(posedge clk); #1;
    imem_req_ready = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    imem_req_ready = 1'b1;
    wait_fires("t6_one_out", 1, 10);
    imem_req_ready = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    stray = 1'b1;
    @(posedge clk); #1;
    stray = 1'b0;
    @(negedge clk);
    check_eq("t6_stray_ignored", 32'(instr_valid), 32'h0);
    @(posedge clk); #1;
    imem_req_ready = 1'b1;
    @(posedge clk); #1;
    imem_req_ready = 1'b0;
    wait_pop("t6_first", 20);
    check_eq("t6_first_pc", last_pop_pc, RST_PC);
`ifdef FETCH_PERF_EN
    check_eq("t6_perf_fetched", perf_fetched, 32'h1);
`endif

    // Random traffic with occasional redirects
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      imem_req_ready  = ($urandom_range(3) != 0);
      instr_ready     = ($urandom_range(9) < 7);
      redirect        = ($urandom_range(19) == 0);
      redirect_target = $urandom();
      if ($urandom_range(15) == 0) lat = $urandom_range(4, 1);
    end

    // Drain: stop issuing, let everything in flight retire
    @(posedge clk); #1;
    redirect = 1'b0;
    imem_req_ready = 1'b0;
    instr_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (pend_q.size() == 0 && exp_q.size() == 0) break;
    end
    repeat (4) @(posedge clk);
    #1;
    check_eq("drain_sb_empty", 32'(exp_q.size()), 32'h0);
    check_eq("drain_mem_empty", 32'(pend_q.size()), 32'h0);
    @(negedge clk);
    check_eq("drain_idle", 32'(instr_valid), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
